// File: rtl/quad_demux4_seq.sv
// One-to-four demultiplexer with a registered 1-entry buffer per lane.
// The destination is either addressed by InS or chosen by a round-robin pointer.
module quad_demux4_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] InData,
  input  logic [1:0]       InS,
  input  logic             InValid,
  output logic             InReady,
  input  logic             Mode,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic [WIDTH-1:0] OutC,
  output logic [WIDTH-1:0] OutD,
  output logic [3:0]       OutValid,
  input  logic [3:0]       OutReady,
  output logic [1:0]       Ptr
);

  logic [WIDTH-1:0] laneData [4];
  logic [3:0]       laneValid;
  logic [3:0]       laneDrain;
  logic [1:0]       ptrQ;
  logic [1:0]       target;
  logic             xferIn;

  always_comb begin
    target    = Mode ? ptrQ : InS;
    laneDrain = laneValid & OutReady;
    // A full target lane still accepts when it is being drained this cycle.
    InReady   = !laneValid[target] || laneDrain[target];
    xferIn    = InValid && InReady;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        laneData[i] <= '0;
      end
      laneValid <= '0;
      ptrQ      <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (xferIn && (target == 2'(i))) begin
          laneData[i]  <= InData;
          laneValid[i] <= 1'b1;
        end else if (laneDrain[i]) begin
          laneValid[i] <= 1'b0;
        end
      end
      if (xferIn && Mode) begin
        ptrQ <= ptrQ + 2'd1;
      end
    end
  end

  assign OutA     = laneData[0];
  assign OutB     = laneData[1];
  assign OutC     = laneData[2];
  assign OutD     = laneData[3];
  assign OutValid = laneValid;
  assign Ptr      = ptrQ;

endmodule

// File: tb/tb_quad_demux4_seq.sv
// Directed bench for quad_demux4_seq: addressed and round-robin routing,
// backpressure, same-cycle drain/fill, mode switching and async reset.
module tb_quad_demux4_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] InData;
  logic [1:0] InS;
  logic       InValid;
  logic       InReady;
  logic       Mode;
  logic [3:0] OutA, OutB, OutC, OutD;
  logic [3:0] OutValid;
  logic [3:0] OutReady;
  logic [1:0] Ptr;

  int nChecks = 0;
  int nErrors = 0;

  quad_demux4_seq #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .InData   (InData),
    .InS      (InS),
    .InValid  (InValid),
    .InReady  (InReady),
    .Mode     (Mode),
    .OutA     (OutA),
    .OutB     (OutB),
    .OutC     (OutC),
    .OutD     (OutD),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Ptr      (Ptr)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle inputs/outputs away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] laneOut(input int lane);
    case (lane)
      0:       return OutA;
      1:       return OutB;
      2:       return OutC;
      default: return OutD;
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; InData = '0; InS = '0; InValid = 1'b0; Mode = 1'b0; OutReady = '0;
    #3;
    checkVal("rst_valid", OutValid, 4'b0000);
    checkVal("rst_ptr",   Ptr, 2'd0);
    checkVal("rst_outA",  OutA, 4'h0);
    checkVal("rst_ready", InReady, 1'b1);

    // No transfer recorded while reset is held, even with InValid high.
    InValid = 1'b1; InData = 4'h9;
    step();
    checkVal("rst_noxfer", OutValid, 4'b0000);
    InValid = 1'b0;
    #2 rst_n = 1'b1;

    // Addressed fill to lane C.
    @(negedge clk);
    Mode = 1'b0; InS = 2'd2; InData = 4'hA; InValid = 1'b1;
    #1 checkVal("fillC_ready", InReady, 1'b1);
    step();
    InValid = 1'b0;
    checkVal("fillC_valid", OutValid, 4'b0100);
    checkVal("fillC_data",  OutC, 4'hA);
    checkVal("fillC_outA",  OutA, 4'h0);

    // Backpressure on lane B.
    InS = 2'd1; InData = 4'h3; InValid = 1'b1;
    step();
    checkVal("bp_hold_valid", OutValid, 4'b0110);
    InData = 4'h7;
    #1 checkVal("bp_notready", InReady, 1'b0);
    step();
    checkVal("bp_stable", OutB, 4'h3);
    OutReady = 4'b0010;
    #1 checkVal("bp_ready", InReady, 1'b1);
    step();
    checkVal("bp_newB",   OutB, 4'h7);
    checkVal("bp_validB", OutValid, 4'b0110);
    InValid = 1'b0; OutReady = 4'b1111;
    step();
    checkVal("drain_all", OutValid, 4'b0000);

    // Non-target lane full and stalled does not affect InReady.
    OutReady = 4'b0000; InS = 2'd0; InData = 4'h1; InValid = 1'b1;
    step();
    InS = 2'd1; InValid = 1'b0;
    #1 checkVal("indep_ready", InReady, 1'b1);
    OutReady = 4'b1111;
    step();

    // Round-robin wrap: words 1..5 into A,B,C,D,A.
    Mode = 1'b1; OutReady = 4'b1111;
    for (int k = 1; k <= 5; k++) begin
      checkVal($sformatf("rr_ptr%0d", k), Ptr, 32'((k - 1) % 4));
      InData = 4'(k); InValid = 1'b1;
      step();
      checkVal($sformatf("rr_valid%0d", k), OutValid, 32'(1 << ((k - 1) % 4)));
      checkVal($sformatf("rr_data%0d", k), laneOut((k - 1) % 4), 32'(k));
    end
    checkVal("rr_ptr_end", Ptr, 2'd1);
    InValid = 1'b0;
    step();

    // Same-cycle drain and fill on lane D.
    Mode = 1'b0; OutReady = 4'b0000; InS = 2'd3; InData = 4'h9; InValid = 1'b1;
    step();
    checkVal("df_first", OutD, 4'h9);
    OutReady = 4'b1000; InData = 4'hE;
    #1 checkVal("df_ready", InReady, 1'b1);
    step();
    checkVal("df_valid", OutValid, 4'b1000);
    checkVal("df_data",  OutD, 4'hE);
    InValid = 1'b0; OutReady = 4'b1111;
    step();

    // Mode switch with Ptr retained (Ptr currently 1).
    Mode = 1'b1; InData = 4'h2; InValid = 1'b1;
    step();
    checkVal("ms_ptr2", Ptr, 2'd2);
    Mode = 1'b0; InS = 2'd0; InData = 4'h6;
    step();
    checkVal("ms_laneA", OutA, 4'h6);
    checkVal("ms_validA", OutValid, 4'b0001);
    checkVal("ms_ptrhold", Ptr, 2'd2);
    Mode = 1'b1; InData = 4'h8;
    step();
    checkVal("ms_laneC", OutC, 4'h8);
    checkVal("ms_validC", OutValid, 4'b0100);
    checkVal("ms_ptr3", Ptr, 2'd3);
    InValid = 1'b0;
    step();
    checkVal("idle_ptr", Ptr, 2'd3);
    checkVal("idle_valid", OutValid, 4'b0000);

    // Fill all lanes, then async reset between edges.
    Mode = 1'b0; OutReady = 4'b0000; InValid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      InS = 2'(k); InData = 4'(15 - k);
      step();
    end
    InValid = 1'b0;
    checkVal("full_valid", OutValid, 4'b1111);
    checkVal("full_ptr", Ptr, 2'd3);
    checkVal("full_D", OutD, 4'hC);
    #2 rst_n = 1'b0;
    #1;
    checkVal("arst_valid", OutValid, 4'b0000);
    checkVal("arst_A", OutA, 4'h0);
    checkVal("arst_D", OutD, 4'h0);
    checkVal("arst_ptr", Ptr, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checkVal("post_rst_idle", OutValid, 4'b0000);

    // First transfer after reset release.
    Mode = 1'b1; InData = 4'h5; InValid = 1'b1;
    step();
    InValid = 1'b0;
    checkVal("post_rst_A", OutA, 4'h5);
    checkVal("post_rst_ptr", Ptr, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/quad_demux4_seq.md
QUAD_DEMUX4_SEQ -- requirements
Module: quad_demux4_seq

Interface
REQ-001 Parameter WIDTH, default 4: data width of the input bus and of each output lane.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 InData  input  WIDTH  data word offered by the upstream source.
REQ-005 InS  input  2  destination lane select in addressed mode: 0=A, 1=B, 2=C, 3=D.
REQ-006 InValid  input  1  InData/InS valid this cycle.
REQ-007 InReady  output  1  block accepts InData this cycle.
REQ-008 Mode  input  1  routing mode: 0=addressed by InS, 1=round-robin by internal pointer.
REQ-009 OutA, OutB, OutC, OutD  output  WIDTH each  registered lane data.
REQ-010 OutValid  output  4  per-lane valid; bit0=A .. bit3=D.
REQ-011 OutReady  input  4  per-lane downstream ready; bit0=A .. bit3=D.
REQ-012 Ptr  output  2  current round-robin pointer.

Function
REQ-013 Each lane SHALL hold one 1-entry register: data plus a valid flag.
REQ-014 Target lane SHALL be InS when Mode=0 and Ptr when Mode=1, evaluated combinationally in the current cycle.
REQ-015 InReady SHALL be 1 iff the target lane is empty or drains this cycle (its OutValid=1 and OutReady=1).
REQ-016 Transfer in SHALL occur iff InValid=1 and InReady=1; on the next edge the target lane captures InData and sets valid.
REQ-017 Input-to-output latency SHALL be exactly one cycle.
REQ-018 Lane drain SHALL occur iff OutValid[i]=1 and OutReady[i]=1; on the next edge valid clears unless the same lane is refilled that cycle.
REQ-019 A simultaneous drain and fill on one lane SHALL leave valid=1 with the new data, giving back-to-back throughput of 1 word per cycle per lane.
REQ-020 Lanes SHALL drain independently; drains on non-target lanes SHALL not affect InReady.
REQ-021 Lane data SHALL stay stable while OutValid[i]=1 and OutReady[i]=0.
REQ-022 Ptr SHALL increment by 1 modulo 4 (3 wraps to 0) on each transfer in while Mode=1.
REQ-023 Ptr SHALL hold when Mode=0 or when no transfer in occurs.
REQ-024 A Mode change SHALL take effect in the cycle it is applied; Ptr is retained across mode changes.
REQ-025 When InValid=0, InReady SHALL still reflect target-lane status, and no state changes except drains.
REQ-026 Non-target lanes SHALL never be written.
REQ-027 OutA..OutD SHALL be driven directly from the lane registers, with no combinational path from InData.

Reset
REQ-028 On rst_n=0, immediately and independent of clk: OutValid=4'b0000, OutA..OutD=0, Ptr=0.
REQ-029 During reset, InReady SHALL evaluate as 1, because all lanes are empty; no transfer is recorded until rst_n=1.
REQ-030 Reset asserted mid-operation SHALL discard all held words, with no further OutValid until new transfers occur.
REQ-031 Reset deassertion SHALL be sampled synchronously; the first transfer is possible on the first edge with rst_n=1.

Verification
REQ-032 Addressed fill: Mode=0, InS=2, InData=4'hA, InValid=1 for one cycle -> next cycle OutValid=4'b0100, OutC=4'hA; other lanes unchanged.
REQ-033 Backpressure: lane B holds 4'h3 with OutReady[1]=0, then InS=1 with InData=4'h7 -> InReady=0, OutB stays 4'h3; raising OutReady[1] -> InReady=1 and OutB=4'h7 on the next edge.
REQ-034 Round-robin wrap: Mode=1, OutReady=4'b1111, five consecutive words 1,2,3,4,5 -> lanes A,B,C,D,A receive them in order; Ptr sequence 0,1,2,3,0,1.
REQ-035 Same-cycle drain and fill: lane D valid, OutReady[3]=1, new word 4'hE to lane D in the same cycle -> OutValid[3] stays 1 and OutD=4'hE next cycle.
REQ-036 Mode switch: Mode=1 with Ptr=2, switch to Mode=0 with InS=0 -> word lands in lane A and Ptr stays 2; return to Mode=1 -> next word lands in lane C.
REQ-037 Async reset: assert rst_n=0 between clock edges with lanes full and Ptr=3 -> OutValid=0, outputs=0 and Ptr=0 immediately, before the next clk edge.
